// File: rtl/logo_pkg.sv
// Shared title-logo geometry and loader state encoding.
// The start-screen reader imports the same constants, so the reader and the writer agree on the pixel layout.
package logo_pkg;

    localparam int LOGO_X0     = 144;
    localparam int LOGO_Y0     = 40;
    localparam int LOGO_W      = 352;
    localparam int LOGO_H      = 176;
    localparam int LOGO_PIXELS = LOGO_W * LOGO_H;
    localparam int LOGO_ADDR_W = 16;
    localparam int LOGO_PIX_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_LO = 2'd1,
        LOAD_HI = 2'd2,
        DONE    = 2'd3
    } loader_state_e;

endpackage

// File: rtl/logo_loader.sv
// Logo RAM writer: takes a valid/ready byte stream and unpacks each byte into two pixel writes.
// It writes every pixel of the logo in order, starting at address 0, and then holds done.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no load in progress, waiting for start
// LOAD_LO | ready for a byte; the even nibble is written on handshake
// LOAD_HI | writes the held odd nibble, then advances the address
// DONE    | every pixel has been written; done stays high
module logo_loader #(
    parameter int LOGO_W = logo_pkg::LOGO_W,
    parameter int LOGO_H = logo_pkg::LOGO_H,
    parameter int ADDR_W = logo_pkg::LOGO_ADDR_W,
    parameter int PIX_W  = logo_pkg::LOGO_PIX_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);
    import logo_pkg::*;

    localparam int PIXELS = LOGO_W * LOGO_H;
    localparam logic [ADDR_W:0] END_ADDR = (ADDR_W + 1)'(PIXELS);

    if (PIXELS % 2 != 0) begin : g_chk_even
        $error("logo_loader: LOGO_W*LOGO_H must be even");
    end
    if (longint'(PIXELS) > (longint'(1) << ADDR_W)) begin : g_chk_fit
        $error("logo_loader: LOGO_W*LOGO_H does not fit in ADDR_W bits");
    end
    if (2 * PIX_W != 8) begin : g_chk_pack
        $error("logo_loader: one byte must carry exactly two pixels");
    end

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [PIX_W-1:0]  hold_q, hold_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   a_plus2;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        hold_d    = hold_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        // One bit wider than the address so that the end compare still works when the logo fills the whole address space.
        a_plus2   = {1'b0, a_q} + (ADDR_W + 1)'(2);

        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = LOAD_LO;
                        a_d     = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                LOAD_LO: begin
                    if (in_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = a_q;
                        wr_data_d = in_data[PIX_W-1:0];
                        hold_d    = in_data[2*PIX_W-1:PIX_W];
                        state_d   = LOAD_HI;
                    end
                end
                LOAD_HI: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = a_q + ADDR_W'(1);
                    wr_data_d = hold_q;
                    a_d       = a_plus2[ADDR_W-1:0];
                    if (a_plus2 == END_ADDR) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD_LO;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            hold_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            hold_q    <= hold_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == LOAD_LO);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_logo_loader.sv
// Self-checking bench for logo_loader: a vector table, hand-written corner sequences, and a write-stream model.
// The model builds the expected write list from the bytes it accepts: byte k after a start gives (2k, lo) and then (2k+1, hi).
module tb_logo_loader;
    import logo_pkg::*;

    localparam int NBYTES = LOGO_PIXELS / 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [3:0]  wr_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        bit         st;
        bit         ab;
        bit         v;
        logic [7:0] d;
        bit         e_rdy;
        bit         e_wen;
        int         e_addr;
        int         e_data;
        bit         e_busy;
        bit         e_done;
    } vec_t;

    wr_t        exp_q[$];
    vec_t       vt[13];
    logic [7:0] byte_mem[NBYTES];
    bit         mon_en = 1'b0;
    bit         loading = 1'b0;
    bit         hs_flag = 1'b0;
    int         base = 0;
    int         last_hs_cyc = -1;
    int         writes_seen = 0;

    always #5 Clk = ~Clk;

    logo_loader #(
        .LOGO_W(LOGO_W),
        .LOGO_H(LOGO_H),
        .ADDR_W(LOGO_ADDR_W),
        .PIX_W (LOGO_PIX_W)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (start),
        .abort   (abort),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sets the inputs for the next edge and updates the model with what that edge will do.
    task automatic drive(input bit st, input bit ab, input bit v, input logic [7:0] d, input bit rst);
        start    = st;
        abort    = ab;
        in_valid = v;
        in_data  = d;
        Reset    = rst;
        hs_flag  = v && (in_ready === 1'b1) && !ab && !rst;
        if (ab || rst) begin
            exp_q.delete();
            loading = 1'b0;
        end else begin
            if (st && !loading) begin
                loading = 1'b1;
                base    = 0;
            end
            if (hs_flag) begin
                exp_q.push_back('{cyc + 1, base, int'(d[3:0])});
                exp_q.push_back('{cyc + 2, base + 1, int'(d[7:4])});
                base += 2;
                last_hs_cyc = cyc + 1;
                if (base == LOGO_PIXELS) loading = 1'b0;
            end
        end
    endtask

    task automatic tick();
        wr_t e;
        @(posedge Clk);
        #1;
        cyc++;
        if (mon_en) begin
            if (wr_en === 1'b1) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0d, no write expected (cycle %0d)",
                             wr_addr, wr_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_addr", int'(wr_addr), e.addr);
                    check("wr_data", int'(wr_data), e.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_write: wr_en 0, expected addr %0d data %0d (cycle %0d)",
                         exp_q[0].addr, exp_q[0].data, cyc);
                e = exp_q.pop_front();
            end
            check("in_ready", int'(in_ready), int'(loading && (last_hs_cyc != cyc)));
        end
    endtask

    task automatic stream_bytes(input int nbytes, input bit gaps);
        int k = 0;
        int guard = 0;
        bit v = 1'b0;
        while (k < nbytes && guard < nbytes * 8 + 16) begin
            if (!gaps) v = 1'b1;
            else if (!v) v = ($urandom_range(0, 2) != 0);
            drive(1'b0, 1'b0, v, byte_mem[k], 1'b0);
            tick();
            guard++;
            if (hs_flag) begin
                k++;
                if (gaps) v = 1'b0;
            end
        end
        check("stream_bytes_accepted", k, nbytes);
    endtask

    task automatic setv(input int i, input bit st, input bit ab, input bit v, input logic [7:0] d,
                        input bit rdy, input bit wen, input int addr, input int data,
                        input bit bsy, input bit dn);
        vt[i] = '{st, ab, v, d, rdy, wen, addr, data, bsy, dn};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NBYTES; i++) byte_mem[i] = 8'($urandom);

        //      i  st ab v  data   rdy wen addr data busy done
        setv(0,  1, 0, 0, 8'h00, 1,  0,  0,   0,   1,   0);
        setv(1,  0, 0, 1, 8'hA5, 0,  1,  0,   5,   1,   0);
        setv(2,  0, 0, 1, 8'hA5, 1,  1,  1,   10,  1,   0);
        setv(3,  0, 0, 0, 8'h00, 1,  0,  0,   0,   1,   0);
        setv(4,  1, 0, 0, 8'h00, 1,  0,  0,   0,   1,   0);
        setv(5,  0, 0, 1, 8'h3C, 0,  1,  2,   12,  1,   0);
        setv(6,  0, 1, 1, 8'h77, 0,  0,  0,   0,   0,   0);
        setv(7,  0, 0, 1, 8'h11, 0,  0,  0,   0,   0,   0);
        setv(8,  1, 1, 0, 8'h00, 0,  0,  0,   0,   0,   0);
        setv(9,  1, 0, 0, 8'h00, 1,  0,  0,   0,   1,   0);
        setv(10, 0, 0, 1, 8'h96, 0,  1,  0,   6,   1,   0);
        setv(11, 0, 0, 0, 8'h00, 1,  1,  1,   9,   1,   0);
        setv(12, 0, 1, 0, 8'h00, 0,  0,  0,   0,   0,   0);

        drive(0, 0, 0, 8'h00, 1);
        tick();
        tick();
        drive(0, 0, 0, 8'h00, 0);
        repeat (10) tick();
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_wr_addr", int'(wr_addr), 0);
        check("reset_wr_data", int'(wr_data), 0);

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].st, vt[i].ab, vt[i].v, vt[i].d, 1'b0);
            tick();
            check($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vt[i].e_rdy));
            check($sformatf("vec%0d_wr_en", i), int'(wr_en), int'(vt[i].e_wen));
            if (vt[i].e_wen) begin
                check($sformatf("vec%0d_wr_addr", i), int'(wr_addr), vt[i].e_addr);
                check($sformatf("vec%0d_wr_data", i), int'(wr_data), vt[i].e_data);
            end
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].e_busy));
            check($sformatf("vec%0d_done", i), int'(done), int'(vt[i].e_done));
        end

        mon_en = 1'b1;

        // Abort while the odd nibble of byte 0x3C at A=100 is held.
        drive(1, 0, 0, 8'h00, 0);
        tick();
        stream_bytes(50, 0);
        drive(0, 0, 0, 8'h00, 0);
        tick();
        drive(0, 0, 1, 8'h3C, 0);
        tick();
        check("abort_lo_addr", int'(wr_addr), 100);
        check("abort_lo_data", int'(wr_data), 12);
        drive(0, 1, 1, 8'h3C, 0);
        tick();
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        drive(0, 0, 0, 8'h00, 0);
        repeat (3) tick();
        drive(1, 0, 0, 8'h00, 0);
        tick();
        check("restart_in_ready", int'(in_ready), 1);
        drive(0, 0, 1, 8'h5A, 0);
        tick();
        check("restart_addr", int'(wr_addr), 0);
        check("restart_data", int'(wr_data), 10);
        drive(0, 0, 0, 8'h00, 0);
        tick();

        // Reset arriving with byte 500 on the bus.
        drive(0, 1, 0, 8'h00, 0);
        tick();
        drive(1, 0, 0, 8'h00, 0);
        tick();
        stream_bytes(500, 0);
        drive(0, 0, 1, byte_mem[500], 1);
        tick();
        check("rst500_wr_en", int'(wr_en), 0);
        check("rst500_wr_addr", int'(wr_addr), 0);
        check("rst500_wr_data", int'(wr_data), 0);
        check("rst500_busy", int'(busy), 0);
        check("rst500_done", int'(done), 0);
        check("rst500_in_ready", int'(in_ready), 0);
        drive(0, 0, 0, 8'h00, 0);
        repeat (4) tick();

        // Random valid gaps; the source holds each byte until it is accepted.
        drive(1, 0, 0, 8'h00, 0);
        tick();
        stream_bytes(1500, 1);
        drive(0, 1, 0, 8'h00, 0);
        tick();
        check("gap_abort_wr_en", int'(wr_en), 0);
        drive(0, 0, 0, 8'h00, 0);
        tick();

        // Full logo with in_valid held high.
        drive(1, 0, 0, 8'h00, 0);
        tick();
        writes_seen = 0;
        stream_bytes(NBYTES, 0);
        drive(0, 0, 0, 8'h00, 0);
        tick();
        check("full_last_addr", int'(wr_addr), LOGO_PIXELS - 1);
        check("full_done", int'(done), 1);
        check("full_busy", int'(busy), 0);
        repeat (3) tick();
        check("full_done_hold", int'(done), 1);
        check("full_busy_hold", int'(busy), 0);
        check("full_wr_en_idle", int'(wr_en), 0);
        check("full_write_count", writes_seen, LOGO_PIXELS);
        check("full_pending", exp_q.size(), 0);

        // start and abort together while done: abort wins.
        drive(1, 1, 0, 8'h00, 0);
        tick();
        check("done_abort_done", int'(done), 0);
        check("done_abort_busy", int'(busy), 0);
        check("done_abort_in_ready", int'(in_ready), 0);
        drive(0, 0, 0, 8'h00, 0);
        repeat (2) tick();
        check("done_abort_stays_idle", int'(in_ready), 0);
        check("done_abort_busy_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logo_loader.md
Name: logo_loader

Overview:
- Writer side of the title-logo pixel memory. The start screen reads that memory by linear address (DrawX-144) + (DrawY-40)*352.
- Accepts a valid/ready byte stream of packed 4-bit palette indices and unpacks each byte into two sequential memory writes.
- Covers the full 352x176 logo (61952 pixels, 30976 bytes), then holds done.
- Sits between the boot-time asset source (UART/flash streamer) and the logo RAM write port.

Parameters:
- LOGO_W, 352, logo width in pixels
- LOGO_H, 176, logo height in pixels
- ADDR_W, 16, write address width; must satisfy 2^ADDR_W >= LOGO_W*LOGO_H
- PIX_W, 4, palette index width; byte carries two pixels

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from address 0
- abort  in  1  one-cycle pulse; cancels an in-progress load
- in_data  in  8  packed pixels; [3:0] = even pixel, [7:4] = odd pixel
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- wr_en  out  1  logo RAM write strobe
- wr_addr  out  ADDR_W  logo RAM write address
- wr_data  out  PIX_W  logo RAM write data
- busy  out  1  load in progress
- done  out  1  full logo written; level signal

Behaviour:
- Reset is synchronous and active-high on Clk. Reset values: state IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, in_ready=0, internal address counter A=0. Reset mid-load abandons the load; no further writes are issued.
- States: IDLE, LOAD_LO, LOAD_HI, DONE. All outputs except in_ready are registered. in_ready = (state==LOAD_LO), decoded from registered state.
- IDLE or DONE, start=1 and abort=0:
  - Next state LOAD_LO, A=0, busy=1, done=0, wr_en=0.
  - Start from DONE restarts the load.
- LOAD_LO, in_valid=1 (handshake):
  - Next cycle: wr_en=1, wr_addr=A, wr_data=in_data[3:0].
  - in_data[7:4] is latched in a hold register; state becomes LOAD_HI.
- LOAD_LO, in_valid=0: wr_en=0 next cycle; no other change.
- LOAD_HI (always exactly one cycle):
  - Next cycle: wr_en=1, wr_addr=A+1, wr_data=hold, A=A+2.
  - If A+2 == LOGO_W*LOGO_H: state DONE, busy=0, done=1. Otherwise state LOAD_LO.
- DONE: wr_en=0. done stays 1 until start, abort or Reset.
- Latency: handshake to first write = 1 cycle; second write follows on the next cycle.
- Throughput: at most 1 byte per 2 cycles. in_ready is low in LOAD_HI.
- abort has priority over start and in_valid in every state. Next cycle: state IDLE, wr_en=0, busy=0, done=0.
  - Abort in LOAD_HI drops the held odd nibble.
  - The byte offered in the abort cycle is not consumed.
- start while busy is ignored.
- Address arithmetic is ADDR_W-bit unsigned. The address never wraps; the final write is at LOGO_W*LOGO_H-1 = 61951.
- LOGO_W*LOGO_H must be even. Elaboration-time assertion if odd or if it exceeds 2^ADDR_W.
- Bytes offered while not in LOAD_LO are not consumed: in_ready=0.

Decomposition:
- Shared package logo_pkg:
  - LOGO_X0=144, LOGO_Y0=40, LOGO_W=352, LOGO_H=176
  - LOGO_PIXELS=61952, LOGO_ADDR_W=16
  - loader state enum (IDLE, LOAD_LO, LOAD_HI, DONE)
- The start-screen region decode shares this package so reader and writer geometry cannot diverge.
- Single module, no sub-module. The FSM, counter and nibble hold are too small to split.

Test Plan:
- Reset then idle 10 cycles -> wr_en, busy, done, in_ready all 0; wr_addr=0.
- start, then byte 0xA5 with in_valid held -> writes (addr 0, data 0x5) then (addr 1, data 0xA) on consecutive cycles; in_ready low during LOAD_HI.
- Full stream of 30976 bytes, in_valid always high -> exactly 61952 writes at addresses 0..61951, no gaps or repeats; done=1 and busy=0 the cycle after the write to 61951; done holds.
- Random in_valid gaps, source holding data until ready -> write sequence identical to the gap-free run; wr_en=0 during gaps.
- abort asserted in LOAD_HI after byte 0x3C at A=100 -> only (100, 0xC) written; next cycle state IDLE, busy=0; a subsequent start restarts at address 0.
- Reset at byte 500 -> next cycle all outputs at reset values; start and done asserted together with abort in the same cycle -> abort wins, state stays IDLE.
